branch_metric_sequencer: RTL and testbench
==========================================

# branch_metric_sequencer

Controller for the shared 2-bit Hamming-distance unit in the Fano decoder datapath. Per request it derives the two expected code symbols (hypothesis bit 0 and 1) from the convolutional encoder state, issues both to the distance unit back-to-back, and collects the two metrics. It then returns both metrics and the preferred branch to the Fano search FSM. A watchdog flags a lost result.

## Interface
- K, 7, constraint length; encoder state width is K-1
- G0, 7'b1111001 (171 octal), generator polynomial for symbol bit 0
- G1, 7'b1011011 (133 octal), generator polynomial for symbol bit 1
- TIMEOUT, 8, maximum WAIT cycles before abort; 4..255

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_vld  in  1  request valid
- i_rdy  out  1  request accepted when i_vld & i_rdy
- i_state  in  K-1  encoder shift-register state; MSB is the most recent bit
- i_sym  in  2  received code symbol
- i_mask  in  2  puncture mask; 1 = bit present
- hd_vld  out  1  request strobe to the distance unit
- hd_mask  out  2  mask to the distance unit
- hd_a  out  2  received symbol to the distance unit
- hd_b  out  2  expected symbol to the distance unit
- hd_o_vld  in  1  distance-unit result valid
- hd_metric  in  2  distance-unit result, 0..2
- o_vld  out  1  result valid; held until o_rdy
- o_rdy  in  1  downstream ready
- o_metric0  out  2  distance for hypothesis 0
- o_metric1  out  2  distance for hypothesis 1
- o_best  out  1  hypothesis with lower metric; tie -> 0
- o_err  out  1  sticky error flag; cleared only by reset

## Operation
- Expected symbol for hypothesis h: r = {h, i_state} (K bits, r[K-1] = h); bit 0 = ^(G0 & r), bit 1 = ^(G1 & r).
- FSM states and transitions:
  - IDLE: i_rdy=1. On acceptance, latch i_state, i_sym and i_mask, then go to ISSUE0.
  - ISSUE0: hd_vld=1, hd_b=symbol(h=0). Go to ISSUE1.
  - ISSUE1: hd_vld=1, hd_b=symbol(h=1). Go to WAIT.
  - WAIT: the first hd_o_vld captures metric0 and the second captures metric1. On the second, register outputs and go to DONE.
  - DONE: o_vld=1. On o_rdy, go to IDLE.
- In ISSUE0 and ISSUE1, hd_a and hd_mask equal the latched i_sym and i_mask. When hd_vld=0, hd_a, hd_b and hd_mask are 0.
- Result counter: a 2-bit count of captured results, cleared on entry to ISSUE0. Results are counted from ISSUE1 onward, so a result arriving in the cycle after ISSUE0 is legal.
- o_best = (o_metric1 < o_metric0).
- Watchdog: counts cycles spent in WAIT. When the count reaches TIMEOUT without the second result:
  - set o_err and go to IDLE;
  - o_vld is not asserted;
  - the request is dropped.
- hd_o_vld in IDLE or DONE is spurious: it is ignored and sets o_err.
- All outputs are registered, including i_rdy.

## Timing
- Reset values: i_rdy=1, hd_vld=0, hd_mask=0, hd_a=0, hd_b=0, o_vld=0, o_metric0=0, o_metric1=0, o_best=0, o_err=0; FSM in IDLE; counters 0.
- Distance unit latency: hd_o_vld is high 2 cycles after the hd_vld cycle.
- Acceptance in cycle 0 gives:
  - hd_vld in cycles 1 and 2;
  - hd_o_vld in cycles 3 and 4;
  - o_vld high from cycle 5.
- With o_rdy=1, the FSM is back in IDLE at cycle 6, so throughput is 1 request per 6 cycles.
- i_rdy deasserts in the cycle after acceptance and reasserts on return to IDLE.
- o_vld & !o_rdy: all o_* outputs hold stable.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight distance result is ignored, because the FSM is in IDLE with no count; this spurious result does not set o_err.

## Structure
- Shared decoder package holds:
  - code-rate constant (2 symbol bits);
  - default K, G0 and G1;
  - FSM state encoding (IDLE, ISSUE0, ISSUE1, WAIT, DONE);
  - metric width constant (2).
- One natural sub-module: expected_symbol_gen, a combinational block with parameters K, G0 and G1; inputs h and state; output 2-bit symbol.
- The distance unit is instantiated outside this block by the parent.

## Test plan
- state=0, i_sym=00, mask=11 -> hd_b=00 in cycle 1 and 11 in cycle 2; o_metric0=0, o_metric1=2, o_best=0; o_vld in cycle 5.
- state=0, i_sym=11, mask=11 -> o_metric0=2, o_metric1=0, o_best=1.
- state=0, i_sym=01, mask=11 -> metrics 1 and 1, tie, o_best=0. Repeat with mask=00 -> metrics 0 and 0, o_best=0.
- Hold o_rdy=0 for 10 cycles after o_vld -> o_vld and outputs stable and i_rdy=0 throughout. Raise o_rdy -> o_vld drops next cycle and i_rdy=1.
- Model suppresses the second hd_o_vld -> o_err=1 after TIMEOUT=8 WAIT cycles, no o_vld, FSM back in IDLE. A following request still completes correctly.
- Assert reset in cycle 3 of a request -> all outputs at reset values asynchronously. The stale hd_o_vld in cycle 4 does not set o_err.

Source files
------------

// File: rtl/branch_metric_sequencer_pkg.sv
// Shared decoder definitions: code rate, default encoder, metric width and
// the branch-metric sequencer state encoding.
package branch_metric_sequencer_pkg;

  localparam int unsigned RATE     = 2;
  localparam int unsigned METRIC_W = 2;
  localparam int unsigned K_DEF    = 7;

  localparam logic [K_DEF-1:0] G0_DEF = 7'b1111001;
  localparam logic [K_DEF-1:0] G1_DEF = 7'b1011011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_ISSUE1,
    ST_WAIT,
    ST_DONE
  } fsm_state_e;

  // Received symbol and puncture mask latched at request acceptance.
  typedef struct packed {
    logic [RATE-1:0] sym;
    logic [RATE-1:0] mask;
  } req_t;

endpackage

// File: rtl/expected_symbol_gen.sv
// Convolutional encoder output for one hypothesis bit h shifted into state.
module expected_symbol_gen
  import branch_metric_sequencer_pkg::*;
#(
  parameter int unsigned     K  = K_DEF,
  parameter logic [K-1:0]    G0 = K'(G0_DEF),
  parameter logic [K-1:0]    G1 = K'(G1_DEF)
) (
  input  logic            h,
  input  logic [K-2:0]    state,
  output logic [RATE-1:0] sym
);

  logic [K-1:0] r;

  assign r   = {h, state};
  assign sym = {^(G1 & r), ^(G0 & r)};

endmodule

// File: rtl/branch_metric_sequencer.sv
// Issues both branch hypotheses to the shared Hamming-distance unit, gathers
// the two metrics and hands them to the Fano search FSM with a watchdog.
module branch_metric_sequencer
  import branch_metric_sequencer_pkg::*;
#(
  parameter int unsigned  K       = K_DEF,
  parameter logic [K-1:0] G0      = K'(G0_DEF),
  parameter logic [K-1:0] G1      = K'(G1_DEF),
  parameter int unsigned  TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_vld,
  output logic                i_rdy,
  input  logic [K-2:0]        i_state,
  input  logic [RATE-1:0]     i_sym,
  input  logic [RATE-1:0]     i_mask,
  output logic                hd_vld,
  output logic [RATE-1:0]     hd_mask,
  output logic [RATE-1:0]     hd_a,
  output logic [RATE-1:0]     hd_b,
  input  logic                hd_o_vld,
  input  logic [METRIC_W-1:0] hd_metric,
  output logic                o_vld,
  input  logic                o_rdy,
  output logic [METRIC_W-1:0] o_metric0,
  output logic [METRIC_W-1:0] o_metric1,
  output logic                o_best,
  output logic                o_err
);

  localparam int unsigned SW   = K - 1;
  localparam int unsigned WD_W = 8;

  fsm_state_e          st_q, st_d;
  logic [SW-1:0]       state_q, state_d;
  req_t                req_q, req_d;
  logic [1:0]          res_cnt_q, res_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [1:0]          settle_q, settle_d;
  logic [METRIC_W-1:0] m0_q, m0_d;

  logic                i_rdy_q, i_rdy_d;
  logic                hd_vld_q, hd_vld_d;
  logic [RATE-1:0]     hd_mask_q, hd_mask_d;
  logic [RATE-1:0]     hd_a_q, hd_a_d;
  logic [RATE-1:0]     hd_b_q, hd_b_d;
  logic                o_vld_q, o_vld_d;
  logic [METRIC_W-1:0] o_metric0_q, o_metric0_d;
  logic [METRIC_W-1:0] o_metric1_q, o_metric1_d;
  logic                o_best_q, o_best_d;
  logic                o_err_q, o_err_d;

  logic                gen_h;
  logic [SW-1:0]       gen_state;
  logic [RATE-1:0]     exp_sym;

  // Symbol for the next issue cycle: h=0 from the incoming state, h=1 from the latched one.
  assign gen_h     = (st_q == ST_ISSUE0);
  assign gen_state = (st_q == ST_IDLE) ? i_state : state_q;

  expected_symbol_gen #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_sym_gen (
    .h     (gen_h),
    .state (gen_state),
    .sym   (exp_sym)
  );

  always_comb begin
    st_d        = st_q;
    state_d     = state_q;
    req_d       = req_q;
    res_cnt_d   = res_cnt_q;
    wd_d        = wd_q;
    m0_d        = m0_q;
    i_rdy_d     = i_rdy_q;
    hd_vld_d    = 1'b0;
    hd_mask_d   = '0;
    hd_a_d      = '0;
    hd_b_d      = '0;
    o_vld_d     = o_vld_q;
    o_metric0_d = o_metric0_q;
    o_metric1_d = o_metric1_q;
    o_best_d    = o_best_q;
    o_err_d     = o_err_q;
    // Results still in flight from before a reset are blanked for two cycles.
    settle_d    = settle_q[1] ? settle_q : settle_q + 2'd1;

    case (st_q)
      ST_IDLE: begin
        if (hd_o_vld && settle_q[1]) o_err_d = 1'b1;
        if (i_vld && i_rdy_q) begin
          state_d    = i_state;
          req_d.sym  = i_sym;
          req_d.mask = i_mask;
          res_cnt_d  = 2'd0;
          i_rdy_d    = 1'b0;
          hd_vld_d   = 1'b1;
          hd_a_d     = i_sym;
          hd_mask_d  = i_mask;
          hd_b_d     = exp_sym;
          st_d       = ST_ISSUE0;
        end
      end
      ST_ISSUE0: begin
        hd_vld_d  = 1'b1;
        hd_a_d    = req_q.sym;
        hd_mask_d = req_q.mask;
        hd_b_d    = exp_sym;
        st_d      = ST_ISSUE1;
      end
      ST_ISSUE1: begin
        if (hd_o_vld) begin
          m0_d      = hd_metric;
          res_cnt_d = 2'd1;
        end
        wd_d = '0;
        st_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hd_o_vld && (res_cnt_q != 2'd0)) begin
          res_cnt_d   = 2'd2;
          o_metric0_d = m0_q;
          o_metric1_d = hd_metric;
          o_best_d    = (hd_metric < m0_q);
          o_vld_d     = 1'b1;
          st_d        = ST_DONE;
        end else begin
          if (hd_o_vld) begin
            m0_d      = hd_metric;
            res_cnt_d = 2'd1;
          end
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            o_err_d = 1'b1;
            i_rdy_d = 1'b1;
            st_d    = ST_IDLE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (hd_o_vld && settle_q[1]) o_err_d = 1'b1;
        if (o_rdy) begin
          o_vld_d = 1'b0;
          i_rdy_d = 1'b1;
          st_d    = ST_IDLE;
        end
      end
      default: begin
        i_rdy_d = 1'b1;
        o_vld_d = 1'b0;
        st_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      state_q     <= '0;
      req_q       <= '0;
      res_cnt_q   <= '0;
      wd_q        <= '0;
      settle_q    <= '0;
      m0_q        <= '0;
      i_rdy_q     <= 1'b1;
      hd_vld_q    <= 1'b0;
      hd_mask_q   <= '0;
      hd_a_q      <= '0;
      hd_b_q      <= '0;
      o_vld_q     <= 1'b0;
      o_metric0_q <= '0;
      o_metric1_q <= '0;
      o_best_q    <= 1'b0;
      o_err_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      state_q     <= state_d;
      req_q       <= req_d;
      res_cnt_q   <= res_cnt_d;
      wd_q        <= wd_d;
      settle_q    <= settle_d;
      m0_q        <= m0_d;
      i_rdy_q     <= i_rdy_d;
      hd_vld_q    <= hd_vld_d;
      hd_mask_q   <= hd_mask_d;
      hd_a_q      <= hd_a_d;
      hd_b_q      <= hd_b_d;
      o_vld_q     <= o_vld_d;
      o_metric0_q <= o_metric0_d;
      o_metric1_q <= o_metric1_d;
      o_best_q    <= o_best_d;
      o_err_q     <= o_err_d;
    end
  end

  assign i_rdy     = i_rdy_q;
  assign hd_vld    = hd_vld_q;
  assign hd_mask   = hd_mask_q;
  assign hd_a      = hd_a_q;
  assign hd_b      = hd_b_q;
  assign o_vld     = o_vld_q;
  assign o_metric0 = o_metric0_q;
  assign o_metric1 = o_metric1_q;
  assign o_best    = o_best_q;
  assign o_err     = o_err_q;

endmodule

// File: tb/tb_branch_metric_sequencer.sv
// Directed bench for branch_metric_sequencer with a 2-cycle distance-unit model.
module tb_branch_metric_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_vld = 1'b0;
  logic       i_rdy;
  logic [5:0] i_state = '0;
  logic [1:0] i_sym = '0;
  logic [1:0] i_mask = '0;
  logic       hd_vld;
  logic [1:0] hd_mask, hd_a, hd_b;
  logic       hd_o_vld;
  logic [1:0] hd_metric;
  logic       o_vld;
  logic       o_rdy = 1'b1;
  logic [1:0] o_metric0, o_metric1;
  logic       o_best, o_err;

  logic       drop = 1'b0;
  logic       inj = 1'b0;
  logic       p1_v = 1'b0, p2_v = 1'b0;
  logic [1:0] p1_m = '0, p2_m = '0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [5:0] st;
    logic [1:0] sym;
    logic [1:0] mask;
    logic [1:0] b0;
    logic [1:0] b1;
    logic [1:0] m0;
    logic [1:0] m1;
    logic       best;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  branch_metric_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .i_vld     (i_vld),
    .i_rdy     (i_rdy),
    .i_state   (i_state),
    .i_sym     (i_sym),
    .i_mask    (i_mask),
    .hd_vld    (hd_vld),
    .hd_mask   (hd_mask),
    .hd_a      (hd_a),
    .hd_b      (hd_b),
    .hd_o_vld  (hd_o_vld),
    .hd_metric (hd_metric),
    .o_vld     (o_vld),
    .o_rdy     (o_rdy),
    .o_metric0 (o_metric0),
    .o_metric1 (o_metric1),
    .o_best    (o_best),
    .o_err     (o_err)
  );

  function automatic logic [1:0] pop2(input logic [1:0] d);
    return {1'b0, d[0]} + {1'b0, d[1]};
  endfunction

  // Distance unit: result two cycles after the request; drop kills one request.
  always @(posedge clk) begin
    p1_v <= hd_vld & ~drop;
    p1_m <= pop2((hd_a ^ hd_b) & hd_mask);
    p2_v <= p1_v;
    p2_m <= p1_m;
  end

  assign hd_o_vld  = p2_v | inj;
  assign hd_metric = p2_m;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents a request in cycle 0; returns just after the accepting edge (cycle 1).
  task automatic start_req(input logic [5:0] st, input logic [1:0] sym,
                           input logic [1:0] mask, input logic rdy);
    @(negedge clk);
    chk("idle_rdy", 8'(i_rdy), 8'd1);
    i_state = st;
    i_sym   = sym;
    i_mask  = mask;
    o_rdy   = rdy;
    i_vld   = 1'b1;
    @(posedge clk);
    #1;
    i_vld = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    start_req(v.st, v.sym, v.mask, 1'b1);
    @(negedge clk);
    chk("c1_hd_vld", 8'(hd_vld), 8'd1);
    chk("c1_hd_b", 8'(hd_b), 8'(v.b0));
    chk("c1_hd_a", 8'(hd_a), 8'(v.sym));
    chk("c1_hd_mask", 8'(hd_mask), 8'(v.mask));
    chk("c1_i_rdy", 8'(i_rdy), 8'd0);
    @(negedge clk);
    chk("c2_hd_vld", 8'(hd_vld), 8'd1);
    chk("c2_hd_b", 8'(hd_b), 8'(v.b1));
    chk("c2_hd_a", 8'(hd_a), 8'(v.sym));
    @(negedge clk);
    chk("c3_hd_idle", 8'({hd_vld, hd_a, hd_b, hd_mask}), 8'd0);
    @(negedge clk);
    chk("c4_o_vld", 8'(o_vld), 8'd0);
    @(negedge clk);
    chk("c5_o_vld", 8'(o_vld), 8'd1);
    chk("c5_metric0", 8'(o_metric0), 8'(v.m0));
    chk("c5_metric1", 8'(o_metric1), 8'(v.m1));
    chk("c5_best", 8'(o_best), 8'(v.best));
    @(negedge clk);
    chk("c6_o_vld", 8'(o_vld), 8'd0);
    chk("c6_i_rdy", 8'(i_rdy), 8'd1);
  endtask

  initial begin
    vecs[0] = '{6'b000000, 2'b00, 2'b11, 2'b00, 2'b11, 2'd0, 2'd2, 1'b0};
    vecs[1] = '{6'b000000, 2'b11, 2'b11, 2'b00, 2'b11, 2'd2, 2'd0, 1'b1};
    vecs[2] = '{6'b000000, 2'b01, 2'b11, 2'b00, 2'b11, 2'd1, 2'd1, 1'b0};
    vecs[3] = '{6'b000000, 2'b01, 2'b00, 2'b00, 2'b11, 2'd0, 2'd0, 1'b0};
    vecs[4] = '{6'b100000, 2'b01, 2'b11, 2'b01, 2'b10, 2'd0, 2'd2, 1'b0};
    vecs[5] = '{6'b000001, 2'b00, 2'b10, 2'b11, 2'b00, 2'd1, 2'd0, 1'b1};
    vecs[6] = '{6'b000110, 2'b10, 2'b01, 2'b10, 2'b01, 2'd0, 2'd1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_i_rdy", 8'(i_rdy), 8'd1);
    chk("rst_outs", 8'({hd_vld, hd_a, hd_b, hd_mask, o_vld}), 8'd0);
    chk("rst_res", 8'({o_metric0, o_metric1, o_best, o_err}), 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-pressure: outputs hold while o_rdy is low.
    start_req(6'b000000, 2'b00, 2'b11, 1'b0);
    repeat (5) @(negedge clk);
    chk("bp_o_vld", 8'(o_vld), 8'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", 8'({o_vld, i_rdy, o_metric0, o_metric1, o_best}), 8'b1_0_00_10_0);
    end
    o_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_vld", 8'(o_vld), 8'd0);
    chk("bp_release_rdy", 8'(i_rdy), 8'd1);

    // Second result lost: watchdog aborts after 8 WAIT cycles.
    start_req(6'b000000, 2'b00, 2'b11, 1'b1);
    @(negedge clk);
    chk("to_c1_hd_vld", 8'(hd_vld), 8'd1);
    @(negedge clk);
    drop = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      drop = 1'b0;
      chk("to_no_vld", 8'(o_vld), 8'd0);
      chk("to_err_early", 8'(o_err), 8'd0);
    end
    @(negedge clk);
    chk("to_err", 8'(o_err), 8'd1);
    chk("to_i_rdy", 8'(i_rdy), 8'd1);
    chk("to_o_vld", 8'(o_vld), 8'd0);
    run_vec(vecs[1]);
    chk("to_err_sticky", 8'(o_err), 8'd1);

    // Reset in cycle 3 of a request; stale results must not raise o_err.
    start_req(6'b000000, 2'b00, 2'b11, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_i_rdy", 8'(i_rdy), 8'd1);
    chk("mr_outs", 8'({hd_vld, hd_a, hd_b, hd_mask, o_vld}), 8'd0);
    chk("mr_res", 8'({o_metric0, o_metric1, o_best, o_err}), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_err", 8'(o_err), 8'd0);
      chk("mr_idle", 8'({i_rdy, o_vld}), 8'b10);
    end

    // Stray distance result in IDLE is flagged.
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("spurious_err", 8'(o_err), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
